// File: rtl/systolic_ws_skew_feeder.sv
// rtl/systolic_ws_skew_feeder.sv - diagonal skew feeder for the weight-stationary PE array west inputs
module systolic_ws_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [0:ROW_NUM-1][DATA_WIDTH-1:0]   in_data,
    input  logic                                 in_last,
    output logic [0:ROW_NUM-1][DATA_WIDTH-1:0]   wests,
    output logic [0:ROW_NUM-1]                   row_valid,
    output logic                                 done
);

    // Counter only ever holds ROW_NUM-1 down to 1, so clog2(ROW_NUM) bits suffice.
    localparam int CNT_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               done_d;
    logic               accept;

    // The array never stalls, so acceptance depends only on our own state.
    assign accept = in_valid && in_ready;

    // Per-lane skew chains: lane i is i+1 registers deep, so its element
    // reaches the array i cycles after row 0. Non-accept cycles inject zero
    // bubbles with a cleared valid bit; every chain shifts every cycle.
    for (genvar i = 0; i < ROW_NUM; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] data_q [0:i];
        logic [i:0]            valid_q;

        // Shift the lane's data and valid chains, loading the head on accept.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= i; k++) begin
                    data_q[k] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q[0]  <= accept ? in_data[i] : '0;
                valid_q[0] <= accept;
                for (int k = 1; k <= i; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end

        assign wests[i]     = data_q[i];
        assign row_valid[i] = valid_q[i];
    end

    // State, drain counter and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
        end
    end

    // Next-state logic: after a last vector, hold off new input until the
    // last row has received its element, then pulse done as it lands.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        in_ready = (state_q != DRAIN);

        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (ROW_NUM == 1) begin
                            // Single lane: the element is already on wests next cycle.
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                            cnt_d   = CNT_W'(ROW_NUM - 1);
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end

            DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                // Guard against 0 as well so a corrupted count cannot wedge the FSM.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ws_skew_feeder.sv
// tb/tb_systolic_ws_skew_feeder.sv - self-checking bench for systolic_ws_skew_feeder
module tb_systolic_ws_skew_feeder;

    localparam int W = 8;
    localparam int R = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid;
    logic                   in_ready;
    logic [0:R-1][W-1:0]    in_data;
    logic                   in_last;
    logic [0:R-1][W-1:0]    wests;
    logic [0:R-1]           row_valid;
    logic                   done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_ws_skew_feeder #(
        .DATA_WIDTH (W),
        .ROW_NUM    (R)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .wests     (wests),
        .row_valid (row_valid),
        .done      (done)
    );

    // Reference model: a history of what was accepted on each of the last R
    // edges. Lane i shows whatever was accepted i edges ago. since_last counts
    // edges since the last "last" accept (-1 when none is pending).
    logic                   hist_v   [0:R-1];
    logic [0:R-1][W-1:0]    hist_vec [0:R-1];
    int                     since_last;
    logic                   exp_ready;
    logic                   exp_done;

    assign exp_ready = !(since_last >= 0 && since_last < R - 1);
    assign exp_done  = (since_last == R - 1);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < R; i++) begin
                hist_v[i]   <= 1'b0;
                hist_vec[i] <= '0;
            end
            since_last <= -1;
        end else begin
            hist_v[0]   <= in_valid && exp_ready;
            hist_vec[0] <= in_data;
            for (int i = 1; i < R; i++) begin
                hist_v[i]   <= hist_v[i-1];
                hist_vec[i] <= hist_vec[i-1];
            end
            if (in_valid && exp_ready && in_last)
                since_last <= 0;
            else if (since_last >= 0 && since_last < R)
                since_last <= since_last + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < R; i++) begin
            check_eq($sformatf("wests[%0d]", i), 32'(wests[i]),
                     hist_v[i] ? 32'(hist_vec[i][i]) : 32'd0);
            check_eq($sformatf("row_valid[%0d]", i), 32'(row_valid[i]), 32'(hist_v[i]));
        end
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check.
    task automatic cycle(input logic v, input logic l, input logic [0:R-1][W-1:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0);
    endtask

    function automatic logic [0:R-1][W-1:0] rand_vec();
        logic [0:R-1][W-1:0] v;
        for (int k = 0; k < R; k++) v[k] = W'($urandom);
        return v;
    endfunction

    initial begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;

        // Reset with random inputs toggling.
        #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_last  = 1'($urandom);
            in_data  = rand_vec();
            #1;
            check_eq("rst_wests", 32'(|wests), 32'd0);
            check_eq("rst_row_valid", 32'(row_valid), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
            check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_outputs();

        // Single last vector.
        cycle(1'b1, 1'b1, {8'd1, 8'd2, 8'd3, 8'd4});
        check_eq("single_w0", 32'(wests[0]), 32'd1);
        check_eq("single_ready_low", 32'(in_ready), 32'd0);
        idle(1);
        check_eq("single_w1", 32'(wests[1]), 32'd2);
        idle(1);
        check_eq("single_w2", 32'(wests[2]), 32'd3);
        check_eq("single_no_done", 32'(done), 32'd0);
        idle(1);
        check_eq("single_w3", 32'(wests[3]), 32'd4);
        check_eq("single_done", 32'(done), 32'd1);
        check_eq("single_ready_back", 32'(in_ready), 32'd1);
        idle(1);
        check_eq("single_done_pulse", 32'(done), 32'd0);
        idle(2);

        // Back-to-back stream.
        cycle(1'b1, 1'b0, {4{8'd1}});
        cycle(1'b1, 1'b0, {4{8'd2}});
        cycle(1'b1, 1'b1, {4{8'd3}});
        check_eq("b2b_w2", 32'(wests[2]), 32'd1);
        idle(5);

        // Bubble in the middle of a stream.
        cycle(1'b1, 1'b0, {4{8'd5}});
        cycle(1'b0, 1'b0, {4{8'd6}});
        check_eq("bubble_rv0", 32'(row_valid[0]), 32'd0);
        cycle(1'b1, 1'b1, {4{8'd7}});
        idle(5);

        // Drain lockout: valid held high through the drain window.
        cycle(1'b1, 1'b1, {4{8'd8}});
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, {4{8'd9}});
        check_eq("lockout_w0", 32'(wests[0]), 32'd0);
        cycle(1'b1, 1'b0, {4{8'd9}});
        check_eq("lockout_next_w0", 32'(wests[0]), 32'd9);
        cycle(1'b1, 1'b1, rand_vec());
        idle(5);

        // Randomized traffic.
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, rand_vec());
        idle(5);

        // Reset in the middle of a drain.
        cycle(1'b1, 1'b1, {8'd11, 8'd12, 8'd13, 8'd14});
        cycle(1'b0, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        check_eq("middrain_wests", 32'(|wests), 32'd0);
        check_eq("middrain_row_valid", 32'(row_valid), 32'd0);
        check_eq("middrain_done", 32'(done), 32'd0);
        check_eq("middrain_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, '0);
            check_eq("middrain_no_done", 32'(done), 32'd0);
        end
        check_eq("middrain_ready_after", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_ws_skew_feeder.md
# systolic_ws_skew_feeder

Input staging stage that sits directly upstream of the weight-stationary systolic PE array and drives its per-row west inputs. It accepts one activation vector per cycle over a valid/ready handshake and applies the diagonal skew the array needs: row i is delayed i cycles relative to row 0. Cycles without an accepted vector become zero bubbles. After a vector flagged last, the block drains the skew pipeline and pulses `done`.

## Interface
- `DATA_WIDTH`, 8, width of each activation element.
- `ROW_NUM`, 8, number of array rows (≥1); one west lane per row.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  `in_data`/`in_last` hold a vector.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_data`  in  `DATA_WIDTH` x [0:ROW_NUM-1]  activation vector, element i is for row i.
- `in_last`  in  1  vector is the last of the current stream.
- `wests`  out  `DATA_WIDTH` x [0:ROW_NUM-1]  skewed activations to the array west inputs; registered.
- `row_valid`  out  [0:ROW_NUM-1]  lane i currently carries accepted data, not a bubble; registered.
- `done`  out  1  one-cycle pulse when the last vector's final element (row ROW_NUM-1) is on `wests`.

## Operation
- Accept occurs on a rising edge where `in_valid && in_ready`.
- Skew structure: lane i has a shift chain of i+1 registers. The head loads `in_data[i]` on accept and loads 0 otherwise. The tail drives `wests[i]`.
- A parallel 1-bit chain of the same depth carries `row_valid[i]`. It loads 1 on accept and 0 otherwise.
- All chains shift every cycle unconditionally. The array is free-running and applies no backpressure.
- FSM states are IDLE, STREAM, and DRAIN.
  - IDLE: `in_ready`=1. Accept with `in_last`=0 goes to STREAM. Accept with `in_last`=1 goes to DRAIN, or, if ROW_NUM=1, stays IDLE and fires `done` on the next edge.
  - STREAM: `in_ready`=1. A cycle with no accept inserts a bubble and the state stays STREAM. Accept with `in_last`=1 goes to DRAIN and loads the drain counter with ROW_NUM-1.
  - DRAIN: `in_ready`=0 and chains shift zeros. The counter decrements each cycle. When the counter reaches 1, the next edge returns the FSM to IDLE and sets `done` for one cycle.
- `in_valid` while `in_ready`=0 is ignored. No data is captured and nothing is buffered.
- `in_ready` is decoded from state only and does not depend combinationally on `in_valid`.
- Data is passed through unmodified, with no arithmetic and no width change.

## Timing
- Reset values: `wests`=0, `row_valid`=0, `done`=0, FSM=IDLE (so `in_ready`=1), drain counter=0.
- Vector accepted at edge n:
  - `wests[i]` = `in_data[i]` and `row_valid[i]`=1 from edge n+1+i to edge n+2+i.
  - Lane latency is i+1 cycles.
  - Full wavefront spans edges n+1 through n+ROW_NUM.
- Last vector accepted at edge n:
  - `in_ready` is low from edge n+1 to edge n+ROW_NUM.
  - `done` is high from edge n+ROW_NUM to edge n+ROW_NUM+1.
  - `in_ready` returns high at edge n+ROW_NUM.
  - A new stream can be accepted at edge n+ROW_NUM. Its row-0 element then coexists on `wests` with the old row ROW_NUM-1 element, as required for back-to-back streams.
- Streaming throughput is one vector per cycle with no bubbles while `in_valid` stays high.
- Reset asserted mid-operation, including in DRAIN: all outputs clear asynchronously, in-flight data is discarded, and no `done` fires.

## Test plan
All scenarios use ROW_NUM=4 and DATA_WIDTH=8.
- Reset: assert `reset` with random inputs -> `wests`=0, `row_valid`=0, `done`=0, `in_ready`=1 throughout reset and on the first cycle after release.
- Single last vector {1,2,3,4} accepted at edge 0 -> `wests[0]`=1 at edge 1, `wests[1]`=2 at edge 2, `wests[2]`=3 at edge 3, `wests[3]`=4 at edge 4. `done`=1 only during edge 4-5. `in_ready`=0 during edges 1-3. All other lane values are 0.
- Back-to-back vectors {1,1,1,1}, {2,2,2,2}, {3,3,3,3} (last) at edges 0,1,2 -> lane i shows 1,2,3 on edges 1+i, 2+i, 3+i with `row_valid` high. `done` at edge 6.
- Bubble: vectors {5,5,5,5} at edge 0, none at edge 1, {7,7,7,7} (last) at edge 2 -> each lane shows 5, then 0 with `row_valid`=0, then 7, shifted by i.
- Drain lockout: hold `in_valid`=1 with {9,9,9,9} during edges 1-3 after a last accept at edge 0 -> nothing captured. The next accept occurs at edge 4, and `wests[0]`=9 at edge 5.
- Reset mid-drain: assert `reset` at edge 2 after a last accept at edge 0 -> outputs go to 0 immediately, `done` never asserts, `in_ready`=1 after release.
